// File: rtl/dispatcher4_rr_if.sv
// Stream bundle for dispatcher4_rr: one valid/ready input stream fanned out to four lanes.
// The slave modport is the dispatcher side; master is the producer/consumer side.
interface dispatcher4_rr_if #(
    parameter int DATA_W = 16
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;

    logic              o_valid0, o_valid1, o_valid2, o_valid3;
    logic [DATA_W-1:0] o_data0, o_data1, o_data2, o_data3;
    logic              i_ready0, i_ready1, i_ready2, i_ready3;
    logic [15:0]       o_cnt0, o_cnt1, o_cnt2, o_cnt3;

    modport slave (
        input  i_valid, i_data, i_ready0, i_ready1, i_ready2, i_ready3,
        output o_ready, o_valid0, o_valid1, o_valid2, o_valid3,
        output o_data0, o_data1, o_data2, o_data3,
        output o_cnt0, o_cnt1, o_cnt2, o_cnt3
    );

    modport master (
        output i_valid, i_data, i_ready0, i_ready1, i_ready2, i_ready3,
        input  o_ready, o_valid0, o_valid1, o_valid2, o_valid3,
        input  o_data0, o_data1, o_data2, o_data3,
        input  o_cnt0, o_cnt1, o_cnt2, o_cnt3
    );
endinterface

// File: rtl/dispatcher4_rr.sv
// Round-robin 1-to-4 dispatcher with a DEPTH-entry FIFO per lane.
// Define DISPATCHER4_RR_CNT_EN to enable the per-lane dispatched-word counters.
module dispatcher4_rr #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input logic            i_clk,
    input logic            i_reset,
    dispatcher4_rr_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [1:0] lane_t;

    logic [DATA_W-1:0] mem    [4][DEPTH];
    logic [AW-1:0]     wr_ptr [4];
    logic [AW-1:0]     rd_ptr [4];
    logic [CW-1:0]     count  [4];
    lane_t             ptr;
    lane_t             target;
    logic [3:0]        rdy, full, valid, push, pop;
    logic              ready, accept;

    assign rdy = {bus.i_ready3, bus.i_ready2, bus.i_ready1, bus.i_ready0};

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            full[n]  = (count[n] == CW'(DEPTH));
            valid[n] = (count[n] != '0);
        end
    end

    // Walk the scan order backwards so the earliest non-full lane after ptr wins.
    always_comb begin
        // NOTE: default first so every path assigns target and no latch is inferred.
        target = ptr;
        for (int k = 4; k >= 1; k--) begin
            if (!full[lane_t'(ptr + lane_t'(k))]) target = lane_t'(ptr + lane_t'(k));
        end
    end

    // Fullness uses registered counts only, keeping i_readyN out of the o_ready path.
    assign ready  = !i_reset && !(&full);
    assign accept = bus.i_valid && ready;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            push[n] = accept && (target == lane_t'(n));
            pop[n]  = valid[n] && rdy[n];
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            ptr <= 2'd3;
            for (int n = 0; n < 4; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            if (accept) ptr <= target;
            for (int n = 0; n < 4; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + AW'(1);
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + AW'(1);
                case ({push[n], pop[n]})
                    2'b10:   count[n] <= count[n] + CW'(1);
                    2'b01:   count[n] <= count[n] - CW'(1);
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

    // NOTE: storage is not reset; empty lanes mask their data, so stale entries never leak.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (push[n]) mem[n][wr_ptr[n]] <= bus.i_data;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid0 = valid[0];
    assign bus.o_valid1 = valid[1];
    assign bus.o_valid2 = valid[2];
    assign bus.o_valid3 = valid[3];
    assign bus.o_data0  = valid[0] ? mem[0][rd_ptr[0]] : '0;
    assign bus.o_data1  = valid[1] ? mem[1][rd_ptr[1]] : '0;
    assign bus.o_data2  = valid[2] ? mem[2][rd_ptr[2]] : '0;
    assign bus.o_data3  = valid[3] ? mem[3][rd_ptr[3]] : '0;

`ifdef DISPATCHER4_RR_CNT_EN
    logic [15:0] cnt [4];

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (i_reset)      cnt[n] <= '0;
            else if (push[n]) cnt[n] <= cnt[n] + 16'd1;
        end
    end

    assign bus.o_cnt0 = cnt[0];
    assign bus.o_cnt1 = cnt[1];
    assign bus.o_cnt2 = cnt[2];
    assign bus.o_cnt3 = cnt[3];
`else
    assign bus.o_cnt0 = '0;
    assign bus.o_cnt1 = '0;
    assign bus.o_cnt2 = '0;
    assign bus.o_cnt3 = '0;
`endif
endmodule

// File: tb/tb_dispatcher4_rr.sv
// Bench for dispatcher4_rr: directed scenarios then random traffic, all compared every
// cycle against a queue-based model of the lanes.
module tb_dispatcher4_rr;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dispatcher4_rr_if #(.DATA_W(DATA_W)) bus ();

    dispatcher4_rr #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    logic        valid;
    logic [15:0] data;
    logic [3:0]  rdy;

    assign bus.i_valid  = valid;
    assign bus.i_data   = data;
    assign bus.i_ready0 = rdy[0];
    assign bus.i_ready1 = rdy[1];
    assign bus.i_ready2 = rdy[2];
    assign bus.i_ready3 = rdy[3];

    logic [3:0]  ov;
    logic [15:0] od [4];
    logic [15:0] oc [4];
    assign ov    = {bus.o_valid3, bus.o_valid2, bus.o_valid1, bus.o_valid0};
    assign od[0] = bus.o_data0;
    assign od[1] = bus.o_data1;
    assign od[2] = bus.o_data2;
    assign od[3] = bus.o_data3;
    assign oc[0] = bus.o_cnt0;
    assign oc[1] = bus.o_cnt1;
    assign oc[2] = bus.o_cnt2;
    assign oc[3] = bus.o_cnt3;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per lane, index of the last lane written, word counts.
    logic [15:0] q [4][$];
    int          last = 3;
    logic [15:0] mcnt [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        if (rst) return 1'b0;
        for (int n = 0; n < 4; n++) if (q[n].size() < DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        logic [15:0] ed;
        logic [15:0] ec;
        check("o_ready", 32'(bus.o_ready), 32'(model_ready()));
        for (int n = 0; n < 4; n++) begin
            ed = (q[n].size() != 0) ? q[n][0] : 16'h0;
`ifdef DISPATCHER4_RR_CNT_EN
            ec = mcnt[n];
`else
            ec = 16'h0;
`endif
            check($sformatf("o_valid%0d", n), 32'(ov[n]), 32'(q[n].size() != 0));
            check($sformatf("o_data%0d", n), 32'(od[n]), 32'(ed));
            check($sformatf("o_cnt%0d", n), 32'(oc[n]), 32'(ec));
        end
    endtask

    // Apply one clock edge to the model using the inputs that are stable across it.
    task automatic model_edge();
        int sz [4];
        int tgt;
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                q[n].delete();
                mcnt[n] = 16'h0;
            end
            last = 3;
        end else begin
            tgt = -1;
            for (int n = 0; n < 4; n++) sz[n] = q[n].size();
            for (int k = 1; k <= 4; k++) begin
                if (tgt < 0 && sz[(last + k) % 4] < DEPTH) tgt = (last + k) % 4;
            end
            for (int n = 0; n < 4; n++) begin
                if (sz[n] > 0 && rdy[n]) void'(q[n].pop_front());
            end
            if (valid && tgt >= 0) begin
                q[tgt].push_back(data);
                last = tgt;
                mcnt[tgt] = mcnt[tgt] + 16'd1;
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] r);
        valid = v;
        data  = d;
        rdy   = r;
        cycle();
    endtask

    initial begin
        valid = 1'b0;
        data  = 16'h0;
        rdy   = 4'h0;
        for (int n = 0; n < 4; n++) mcnt[n] = 16'h0;

        // Power-on reset, then one more cycle with reset held: o_ready must be 0.
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive(1'b1, 16'h1234, 4'hF);
        rst = 1'b0;

        // Back-to-back words with all consumers ready land on lanes 0..3.
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'hA0 + i), 4'hF);
        drive(1'b0, 16'h0, 4'hF);
        drive(1'b0, 16'h0, 4'hF);

        // Lane 1 stalled: it fills and is then skipped.
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(16'hB0 + i), 4'b1101);
        #1;
        check("t2_ready", 32'(bus.o_ready), 32'd1);
        check("t2_valid1", 32'(ov[1]), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 4'hF);

        // Fill all lanes, then free one slot on lane 2.
        for (int i = 0; i < 8; i++) drive(1'b1, 16'(16'hC0 + i), 4'h0);
        #1;
        check("t3_full", 32'(bus.o_ready), 32'd0);
        drive(1'b1, 16'hC8, 4'h0);
        drive(1'b0, 16'h0, 4'b0100);
        #1;
        check("t3_ready_back", 32'(bus.o_ready), 32'd1);
        drive(1'b1, 16'hD0, 4'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 4'hF);

        // Push and pop on lane 0 in the same cycle.
        rst = 1'b1;
        drive(1'b0, 16'h0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'hE0 + i), 4'h0);
        drive(1'b1, 16'hE4, 4'b0001);
        drive(1'b0, 16'h0, 4'h0);
        #1;
        check("t4_valid0", 32'(ov[0]), 32'd1);
        check("t4_head0", 32'(od[0]), 32'h00E4);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 4'hF);

        // Reset with buffered words; word offered during reset is ignored.
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'hF0 + i), 4'h0);
        rst = 1'b1;
        drive(1'b1, 16'h0055, 4'hF);
        rst = 1'b0;
        #1;
        check("t5_flushed", 32'(ov), 32'd0);
        drive(1'b1, 16'h0077, 4'hF);
        #1;
        check("t5_lane0", 32'(ov), 32'd1);
        check("t5_data0", 32'(od[0]), 32'h0077);
        drive(1'b0, 16'h0, 4'hF);

        // Five words, all ready: lane 0 gets two.
        rst = 1'b1;
        drive(1'b0, 16'h0, 4'hF);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h60 + i), 4'hF);
        drive(1'b0, 16'h0, 4'hF);
        #1;
`ifdef DISPATCHER4_RR_CNT_EN
        check("t6_cnt0", 32'(oc[0]), 32'd2);
        check("t6_cnt3", 32'(oc[3]), 32'd1);
`else
        check("t6_cnt0", 32'(oc[0]), 32'd0);
        check("t6_cnt3", 32'(oc[3]), 32'd0);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
